// File: rtl/display_uart_pkg.sv
// Shared encodings and UART framing constants for the display buffer streamer.
package display_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } uart_state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         DATA_BITS     = 8;
   localparam int         STOP_BITS     = 1;
   localparam int         BITS_PER_BYTE = 1 + DATA_BITS + STOP_BITS;

   // Total line-busy cycles for a frame of nbytes payload bytes plus the sync byte.
   function automatic int frame_cycles(input int nbytes, input int clk_per_bit);
      return (1 + nbytes) * BITS_PER_BYTE * clk_per_bit;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. ready is also high during the last stop-bit cycle so a
// following byte can be accepted with no idle gap between stop and start bits.
module uart_tx_byte
   import display_uart_pkg::*;
#(
   parameter int ClkPerBit = 868
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   output logic       ready_o,
   output logic       tx_o
);

   localparam int CntW = $clog2(ClkPerBit);

   uart_state_e     state_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      bit_q;
   logic [7:0]      byte_q;
   logic            tx_q;
   logic            bit_end;

   assign bit_end = (cnt_q == CntW'(ClkPerBit - 1));
   assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
   assign tx_o    = tx_q;

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         tx_q    <= 1'b1;
      end else if (ready_o && start_i) begin
         state_q <= ST_START;
         byte_q  <= byte_i;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tx_q  <= 1'b1;
               cnt_q <= '0;
            end
            ST_START: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  tx_q    <= byte_q[0];
                  state_q <= ST_DATA;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (bit_q == 3'(DATA_BITS - 1)) begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     tx_q  <= byte_q[bit_q + 3'd1];
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/display_uart_streamer.sv
// Snapshots DisplayBuffer whenever it differs from the last copy sent and streams
// it as SyncByte followed by the snapshot bytes, least significant byte first.
module display_uart_streamer
   import display_uart_pkg::*;
#(
   parameter int         DisplayBufferSize = 256,
   parameter int         ClkPerBit         = 868,
   parameter logic [7:0] SyncByte          = SYNC_BYTE_DEF
) (
   input  logic                         clk,
   input  logic                         RESET,
   input  logic [DisplayBufferSize-1:0] DisplayBuffer,
   output logic                         tx,
   output logic                         busy,
   output logic                         frame_done
);

   localparam int NBytes = DisplayBufferSize / 8;
   localparam int IdxW   = $clog2(NBytes + 1);

   logic [DisplayBufferSize-1:0] shadow_q;
   logic [NBytes-1:0][7:0]       shadow_bytes;
   logic [IdxW-1:0]              idx_q;
   logic                         busy_q;
   logic                         done_q;

   logic                         tx_ready;
   logic                         detect_d;
   logic                         advance_d;
   logic                         more_d;
   logic                         start_d;
   logic [7:0]                   next_byte_d;
   logic [7:0]                   byte_d;

   assign shadow_bytes = shadow_q;

   // idx_q names the byte on the wire (0 = sync), so payload byte idx_q is next up.
   always_comb begin
      next_byte_d = '0;
      for (int k = 0; k < NBytes; k++) begin
         if (idx_q == IdxW'(k)) next_byte_d = shadow_bytes[k];
      end
   end

   assign detect_d  = !busy_q && (DisplayBuffer != shadow_q);
   assign advance_d = busy_q && tx_ready;
   assign more_d    = (idx_q != IdxW'(NBytes));
   assign start_d   = detect_d || (advance_d && more_d);
   assign byte_d    = detect_d ? SyncByte : next_byte_d;

   always_ff @(posedge clk) begin
      if (RESET) begin
         shadow_q <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= advance_d && !more_d;
         if (detect_d) begin
            shadow_q <= DisplayBuffer;
            idx_q    <= '0;
            busy_q   <= 1'b1;
         end else if (advance_d) begin
            if (more_d) begin
               idx_q <= idx_q + IdxW'(1);
            end else begin
               idx_q  <= '0;
               busy_q <= 1'b0;
            end
         end
      end
   end

   uart_tx_byte #(
      .ClkPerBit(ClkPerBit)
   ) u_tx (
      .clk    (clk),
      .RESET  (RESET),
      .start_i(start_d),
      .byte_i (byte_d),
      .ready_o(tx_ready),
      .tx_o   (tx)
   );

   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_display_uart_streamer.sv
// Directed bench for display_uart_streamer: per-cycle waveform model plus a UART decoder.
module tb_display_uart_streamer;

   localparam int DBS  = 16;
   localparam int CPB  = 4;
   localparam int NB   = DBS / 8;
   localparam int FLEN = (1 + NB) * 10 * CPB;

   logic           clk = 1'b0;
   logic           RESET = 1'b1;
   logic [DBS-1:0] DisplayBuffer = '0;
   logic           tx;
   logic           busy;
   logic           frame_done;

   always #5 clk = ~clk;

   display_uart_streamer #(
      .DisplayBufferSize(DBS),
      .ClkPerBit        (CPB),
      .SyncByte         (8'hA5)
   ) dut (
      .clk          (clk),
      .RESET        (RESET),
      .DisplayBuffer(DisplayBuffer),
      .tx           (tx),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the whole frame is a precomputed per-cycle tx waveform.
   logic [DBS-1:0] m_shadow = '0;
   bit             m_wave[$];
   bit             m_pend = 1'b0;
   bit             m_valid = 1'b0;
   logic           e_tx = 1'b1;
   logic           e_busy = 1'b0;
   logic           e_done = 1'b0;
   logic [7:0]     m_frame[NB+1];

   always @(posedge clk) begin
      m_valid = 1'b1;
      e_done  = 1'b0;
      if (RESET) begin
         m_shadow = '0;
         m_wave.delete();
         m_pend = 1'b0;
         e_tx   = 1'b1;
         e_busy = 1'b0;
      end else if (m_wave.size() > 0) begin
         e_tx   = m_wave.pop_front();
         e_busy = 1'b1;
         m_pend = (m_wave.size() == 0);
      end else if (m_pend) begin
         e_tx   = 1'b1;
         e_busy = 1'b0;
         e_done = 1'b1;
         m_pend = 1'b0;
      end else if (DisplayBuffer != m_shadow) begin
         m_shadow   = DisplayBuffer;
         m_frame[0] = 8'hA5;
         for (int b = 0; b < NB; b++) m_frame[b+1] = m_shadow[8*b +: 8];
         for (int b = 0; b <= NB; b++) begin
            repeat (CPB) m_wave.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (CPB) m_wave.push_back(m_frame[b][i]);
            repeat (CPB) m_wave.push_back(1'b1);
         end
         e_tx   = m_wave.pop_front();
         e_busy = 1'b1;
      end else begin
         e_tx   = 1'b1;
         e_busy = 1'b0;
      end
   end

   // Compare process: every cycle, plus bit-edge alignment and frame length bookkeeping.
   int   cyc = 0;
   int   n_done = 0;
   int   f_start = 0;
   int   last_len = 0;
   logic p_tx = 1'b1;
   logic p_busy = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (m_valid) begin
         chk("tx", 32'(tx), 32'(e_tx));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("frame_done", 32'(frame_done), 32'(e_done));
         if (busy && !p_busy) f_start = cyc;
         if (busy && (tx !== p_tx)) chk("tx_edge_align", 32'((cyc - f_start) % CPB), 32'd0);
         if (frame_done) begin
            n_done++;
            last_len = cyc - f_start;
         end
         p_tx   = tx;
         p_busy = busy;
      end
   end

   // UART decoder: samples each bit at its centre.
   bit         rx_on = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_sh = '0;
   logic [7:0] rx_q[$];

   always @(negedge clk) begin
      if (RESET) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (tx === 1'b0) begin
            rx_on  = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == CPB * 9 + CPB / 2) begin
            chk("rx_stop", 32'(tx), 32'd1);
            rx_q.push_back(rx_sh);
            rx_on = 1'b0;
         end else if ((rx_cnt % CPB == CPB / 2) && (rx_cnt > CPB)) begin
            rx_sh[rx_cnt/CPB-1] = tx;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_done(input string nm);
      for (int k = 0; k < 400; k++) begin
         step(1);
         if (frame_done === 1'b1) break;
      end
      chk({nm, "_done_seen"}, 32'(frame_done), 32'd1);
   endtask

   task automatic check_frame(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
      logic [7:0] exp[3];
      exp[0] = b0;
      exp[1] = b1;
      exp[2] = b2;
      for (int i = 0; i < 3; i++) begin
         if (rx_q.size() > 0) chk($sformatf("%s_byte%0d", nm, i), 32'(rx_q.pop_front()), 32'(exp[i]));
         else chk($sformatf("%s_byte%0d_missing", nm, i), 32'(rx_q.size()), 32'd1);
      end
   endtask

   initial begin
      // Reset with zero buffer: nothing is sent.
      RESET = 1'b1;
      DisplayBuffer = 16'h0000;
      step(3);
      RESET = 1'b0;
      step(200);
      chk("s1_tx", 32'(tx), 32'd1);
      chk("s1_busy", 32'(busy), 32'd0);
      chk("s1_done_cnt", 32'(n_done), 32'd0);
      chk("s1_rx_cnt", 32'(rx_q.size()), 32'd0);

      // Single frame.
      DisplayBuffer = 16'h12C3;
      step(1);
      chk("s2_start_tx", 32'(tx), 32'd0);
      chk("s2_start_busy", 32'(busy), 32'd1);
      wait_done("s2");
      chk("s2_len", 32'(last_len), 32'(FLEN));
      chk("s2_len_lit", 32'(last_len), 32'd120);
      chk("s2_done_cnt", 32'(n_done), 32'd1);
      chk("s2_rx_cnt", 32'(rx_q.size()), 32'd3);
      check_frame("s2", 8'hA5, 8'hC3, 8'h12);
      step(1);
      chk("s2_idle_busy", 32'(busy), 32'd0);

      // Hold buffer equal to shadow.
      step(500);
      chk("s4_done_cnt", 32'(n_done), 32'd1);
      chk("s4_busy", 32'(busy), 32'd0);
      chk("s4_rx_cnt", 32'(rx_q.size()), 32'd0);

      // Changes mid-frame: only the latest value goes out, right after frame_done.
      RESET = 1'b1;
      step(2);
      RESET = 1'b0;
      rx_q.delete();
      step(50);
      DisplayBuffer = 16'h0001;
      step(10);
      DisplayBuffer = 16'h00FF;
      wait_done("s3a");
      step(1);
      chk("s3_back2back_tx", 32'(tx), 32'd0);
      chk("s3_back2back_busy", 32'(busy), 32'd1);
      wait_done("s3b");
      step(200);
      chk("s3_done_cnt", 32'(n_done), 32'd3);
      chk("s3_rx_cnt", 32'(rx_q.size()), 32'd6);
      check_frame("s3a", 8'hA5, 8'hC3, 8'h12);
      check_frame("s3b", 8'hA5, 8'hFF, 8'h00);

      // Reset during the data bits of byte 2.
      DisplayBuffer = 16'h1234;
      step(90);
      chk("s5_mid_busy", 32'(busy), 32'd1);
      RESET = 1'b1;
      DisplayBuffer = 16'h12C3;
      step(1);
      chk("s5_rst_tx", 32'(tx), 32'd1);
      chk("s5_rst_busy", 32'(busy), 32'd0);
      step(1);
      RESET = 1'b0;
      rx_q.delete();
      wait_done("s5");
      chk("s5_len", 32'(last_len), 32'd120);
      chk("s5_done_cnt", 32'(n_done), 32'd4);
      chk("s5_rx_cnt", 32'(rx_q.size()), 32'd3);
      check_frame("s5", 8'hA5, 8'hC3, 8'h12);
      step(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
